// File: rtl/atm_controller_param.sv
// ATM session controller: card/PIN session FSM plus account balance register.
// Saturating deposits, balance-checked withdrawals, attempt counting with lockout.
// Optional macro DAILY_LIMIT_EN adds a per-day withdrawal cap with the
// dia_nuevo input and the limite_excedido output.
module atm_controller_param #(
  parameter int unsigned PIN_DIGITS = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN = 16'h1234,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned MONTO_WIDTH = 32,
  parameter int unsigned BALANCE_WIDTH = 64,
  parameter logic [BALANCE_WIDTH-1:0] INIT_BALANCE = BALANCE_WIDTH'(5000),
  parameter logic [BALANCE_WIDTH-1:0] DAILY_LIMIT = BALANCE_WIDTH'(1000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tarjeta_recibida,
  input  logic                     digito_stb,
  input  logic [3:0]               digito,
  input  logic                     tipo_trans,
  input  logic                     monto_stb,
  input  logic [MONTO_WIDTH-1:0]   monto,
  output logic [BALANCE_WIDTH-1:0] saldo,
  output logic                     balance_actualizado,
  output logic                     entregar_dinero,
  output logic                     pin_incorrecto,
  output logic                     advertencia,
  output logic                     bloqueo,
  output logic                     fondos_insuficientes
`ifdef DAILY_LIMIT_EN
  ,
  input  logic                     dia_nuevo,
  output logic                     limite_excedido
`endif
);

  localparam int CNT_W  = $clog2(PIN_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int BUF_W  = 4 * PIN_DIGITS;
  localparam logic [CNT_W-1:0]  PIN_DIGITS_C = CNT_W'(PIN_DIGITS);
  localparam logic [FAIL_W-1:0] MAX_C        = FAIL_W'(MAX_ATTEMPTS);
  // With a single allowed attempt this is 0, which a post-increment count never equals.
  localparam logic [FAIL_W-1:0] MAX_M1_C     = FAIL_W'(MAX_ATTEMPTS - 1);

  typedef enum logic [2:0] {IDLE, PIN_ENTRY, PIN_CHECK, AMOUNT_WAIT, LOCKED} state_t;

  state_t                   state_reg, state_next;
  logic [BALANCE_WIDTH-1:0] saldo_reg, saldo_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next, cnt_inc;
  logic [BUF_W-1:0]         buf_reg, buf_next;
  logic [BUF_W+3:0]         buf_shifted;
  logic [FAIL_W-1:0]        fail_reg, fail_next, fail_inc;
  logic                     adv_reg, adv_next;
  logic                     blq_reg, blq_next;
  logic                     bal_reg, bal_next;
  logic                     ent_reg, ent_next;
  logic                     pin_reg, pin_next;
  logic                     fondos_reg, fondos_next;
  logic [BALANCE_WIDTH-1:0] monto_ext;
  logic [BALANCE_WIDTH:0]   dep_sum;
`ifdef DAILY_LIMIT_EN
  logic [BALANCE_WIDTH-1:0] acc_reg, acc_next, acc_base;
  logic [BALANCE_WIDTH:0]   acc_sum;
  logic                     lim_reg, lim_next;
`else
  wire unused_daily_limit = ^DAILY_LIMIT;
`endif

  // Session FSM next state, balance arithmetic and registered output values.
  always_comb begin
    state_next  = state_reg;
    saldo_next  = saldo_reg;
    cnt_next    = cnt_reg;
    buf_next    = buf_reg;
    fail_next   = fail_reg;
    adv_next    = adv_reg;
    bal_next    = 1'b0;
    ent_next    = 1'b0;
    pin_next    = 1'b0;
    fondos_next = 1'b0;
    monto_ext   = '0;
    monto_ext[MONTO_WIDTH-1:0] = monto;
    cnt_inc     = cnt_reg + CNT_W'(1);
    fail_inc    = fail_reg + FAIL_W'(1);
    buf_shifted = {buf_reg, digito};
    dep_sum     = {1'b0, saldo_reg} + {1'b0, monto_ext};
`ifdef DAILY_LIMIT_EN
    // A new day clears the accumulator in this very cycle, so a same-cycle
    // withdrawal is judged against zero.
    acc_base = dia_nuevo ? '0 : acc_reg;
    acc_next = acc_base;
    acc_sum  = {1'b0, acc_base} + {1'b0, monto_ext};
    lim_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (tarjeta_recibida) begin
          state_next = PIN_ENTRY;
          cnt_next   = '0;
          buf_next   = '0;
        end
      end
      PIN_ENTRY: begin
        if (!tarjeta_recibida) begin
          state_next = IDLE;
        end else if (digito_stb && (digito <= 4'd9)) begin
          buf_next = buf_shifted[BUF_W-1:0];
          cnt_next = cnt_inc;
          if (cnt_inc == PIN_DIGITS_C) state_next = PIN_CHECK;
        end
      end
      PIN_CHECK: begin
        if (!tarjeta_recibida) begin
          state_next = IDLE;
        end else if (buf_reg == PIN) begin
          fail_next  = '0;
          adv_next   = 1'b0;
          state_next = AMOUNT_WAIT;
        end else begin
          fail_next = fail_inc;
          pin_next  = 1'b1;
          cnt_next  = '0;
          buf_next  = '0;
          if (fail_inc == MAX_C) begin
            state_next = LOCKED;
          end else begin
            state_next = PIN_ENTRY;
            if (fail_inc == MAX_M1_C) adv_next = 1'b1;
          end
        end
      end
      AMOUNT_WAIT: begin
        if (!tarjeta_recibida) begin
          state_next = IDLE;
        end else if (monto_stb) begin
          state_next = IDLE;
          if (!tipo_trans) begin
            saldo_next = dep_sum[BALANCE_WIDTH] ? '1 : dep_sum[BALANCE_WIDTH-1:0];
            bal_next   = 1'b1;
`ifdef DAILY_LIMIT_EN
          end else if (acc_sum > {1'b0, DAILY_LIMIT}) begin
            lim_next   = 1'b1;
`endif
          end else if (monto_ext > saldo_reg) begin
            fondos_next = 1'b1;
          end else begin
            saldo_next = saldo_reg - monto_ext;
            bal_next   = 1'b1;
            ent_next   = 1'b1;
`ifdef DAILY_LIMIT_EN
            acc_next   = acc_sum[BALANCE_WIDTH-1:0];
`endif
          end
        end
      end
      LOCKED: state_next = LOCKED;
      default: state_next = IDLE;
    endcase
    blq_next = (state_next == LOCKED);
  end

  // State and output registers; reset aborts any session and clears the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      saldo_reg  <= INIT_BALANCE;
      cnt_reg    <= '0;
      buf_reg    <= '0;
      fail_reg   <= '0;
      adv_reg    <= 1'b0;
      blq_reg    <= 1'b0;
      bal_reg    <= 1'b0;
      ent_reg    <= 1'b0;
      pin_reg    <= 1'b0;
      fondos_reg <= 1'b0;
`ifdef DAILY_LIMIT_EN
      acc_reg    <= '0;
      lim_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      saldo_reg  <= saldo_next;
      cnt_reg    <= cnt_next;
      buf_reg    <= buf_next;
      fail_reg   <= fail_next;
      adv_reg    <= adv_next;
      blq_reg    <= blq_next;
      bal_reg    <= bal_next;
      ent_reg    <= ent_next;
      pin_reg    <= pin_next;
      fondos_reg <= fondos_next;
`ifdef DAILY_LIMIT_EN
      acc_reg    <= acc_next;
      lim_reg    <= lim_next;
`endif
    end
  end

  assign saldo                = saldo_reg;
  assign balance_actualizado  = bal_reg;
  assign entregar_dinero      = ent_reg;
  assign pin_incorrecto       = pin_reg;
  assign advertencia          = adv_reg;
  assign bloqueo              = blq_reg;
  assign fondos_insuficientes = fondos_reg;
`ifdef DAILY_LIMIT_EN
  assign limite_excedido      = lim_reg;
`endif

endmodule

// File: tb/tb_atm_controller_param.sv
// Table-driven bench for atm_controller_param: one record per clock cycle with
// inputs and the outputs expected right after that edge, plus a hand-written
// saturation sequence on a 16-bit instance.
module tb_atm_controller_param;

  localparam logic [6:0] F_BAL = 7'b1000000;
  localparam logic [6:0] F_ENT = 7'b0100000;
  localparam logic [6:0] F_PIN = 7'b0010000;
  localparam logic [6:0] F_ADV = 7'b0001000;
  localparam logic [6:0] F_BLQ = 7'b0000100;
  localparam logic [6:0] F_FON = 7'b0000010;
  localparam logic [6:0] F_LIM = 7'b0000001;

  typedef struct {
    logic        rst;
    logic        card;
    logic        dstb;
    logic [3:0]  digit;
    logic        mstb;
    logic        tipo;
    logic [31:0] monto;
    logic        dia;
    logic [63:0] exp_saldo;
    logic [6:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        card = 1'b0;
  logic        dstb = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        tipo = 1'b0;
  logic        mstb = 1'b0;
  logic [31:0] monto = 32'd0;
  logic        dia = 1'b0;
  logic [15:0] monto2 = 16'd0;

  logic [63:0] saldo;
  logic bal, ent, pin, adv, blq, fon, lim;
  logic [15:0] saldo2;
  logic bal2, ent2, pin2, adv2, blq2, fon2, lim2;

  always #5 clk = ~clk;

  atm_controller_param u_dut (
    .clk(clk), .rst(rst), .tarjeta_recibida(card), .digito_stb(dstb), .digito(digit),
    .tipo_trans(tipo), .monto_stb(mstb), .monto(monto), .saldo(saldo),
    .balance_actualizado(bal), .entregar_dinero(ent), .pin_incorrecto(pin),
    .advertencia(adv), .bloqueo(blq), .fondos_insuficientes(fon)
`ifdef DAILY_LIMIT_EN
    , .dia_nuevo(dia), .limite_excedido(lim)
`endif
  );

  atm_controller_param #(
    .MONTO_WIDTH(16), .BALANCE_WIDTH(16), .INIT_BALANCE(16'hFFF0)
  ) u_dut16 (
    .clk(clk), .rst(rst), .tarjeta_recibida(card), .digito_stb(dstb), .digito(digit),
    .tipo_trans(tipo), .monto_stb(mstb), .monto(monto2), .saldo(saldo2),
    .balance_actualizado(bal2), .entregar_dinero(ent2), .pin_incorrecto(pin2),
    .advertencia(adv2), .bloqueo(blq2), .fondos_insuficientes(fon2)
`ifdef DAILY_LIMIT_EN
    , .dia_nuevo(dia), .limite_excedido(lim2)
`endif
  );

`ifndef DAILY_LIMIT_EN
  assign lim  = 1'b0;
  assign lim2 = 1'b0;
`endif

  task automatic add(input logic r, input logic c, input logic ds, input logic [3:0] d,
                     input logic ms, input logic t, input logic [31:0] m, input logic dn,
                     input logic [63:0] s, input logic [6:0] f);
    vec_t v;
    v.rst = r; v.card = c; v.dstb = ds; v.digit = d; v.mstb = ms; v.tipo = t;
    v.monto = m; v.dia = dn; v.exp_saldo = s; v.exp_flags = f;
    vecs.push_back(v);
  endtask

  task automatic rstv(input logic [63:0] s);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, s, 7'd0);
  endtask

  task automatic nop(input logic c, input logic [63:0] s, input logic [6:0] f);
    add(1'b0, c, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, s, f);
  endtask

  task automatic dig(input logic [3:0] d, input logic [63:0] s, input logic [6:0] f);
    add(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0, 32'd0, 1'b0, s, f);
  endtask

  task automatic pin4(input logic [15:0] p, input logic [63:0] s, input logic [6:0] f);
    dig(p[15:12], s, f); dig(p[11:8], s, f); dig(p[7:4], s, f); dig(p[3:0], s, f);
  endtask

  task automatic amt(input logic c, input logic t, input logic [31:0] m, input logic dn,
                     input logic [63:0] s, input logic [6:0] f);
    add(1'b0, c, 1'b0, 4'd0, 1'b1, t, m, dn, s, f);
  endtask

  // A full correct-PIN session prefix: insert, four digits, check cycle.
  task automatic login(input logic [63:0] s);
    nop(1'b1, s, 7'd0); pin4(16'h1234, s, 7'd0); nop(1'b1, s, 7'd0);
  endtask

  task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    logic [6:0] act_flags;

    // Test 1: correct PIN, deposit 500.
    rstv(64'd5000);
    login(64'd5000);
    amt(1'b1, 1'b0, 32'd500, 1'b0, 64'd5500, F_BAL);
    // Test 2: insufficient funds, then a valid withdrawal.
    login(64'd5500);
    amt(1'b1, 1'b1, 32'd6000, 1'b0, 64'd5500, F_FON);
    login(64'd5500);
    amt(1'b1, 1'b1, 32'd500, 1'b0, 64'd5000, F_BAL | F_ENT);
    // Test 3: three wrong PINs -> warning then lock; inputs ignored; reset clears.
    nop(1'b1, 64'd5000, 7'd0);
    pin4(16'h1235, 64'd5000, 7'd0);
    nop(1'b1, 64'd5000, F_PIN);
    pin4(16'h1235, 64'd5000, 7'd0);
    nop(1'b1, 64'd5000, F_PIN | F_ADV);
    pin4(16'h1235, 64'd5000, F_ADV);
    nop(1'b1, 64'd5000, F_PIN | F_ADV | F_BLQ);
    nop(1'b0, 64'd5000, F_ADV | F_BLQ);
    nop(1'b1, 64'd5000, F_ADV | F_BLQ);
    dig(4'd1, 64'd5000, F_ADV | F_BLQ);
    amt(1'b1, 1'b0, 32'd100, 1'b0, 64'd5000, F_ADV | F_BLQ);
    rstv(64'd5000);
    // Test 4: invalid digit ignored, card removal, removal beats monto_stb.
    nop(1'b1, 64'd5000, 7'd0);
    dig(4'd1, 64'd5000, 7'd0); dig(4'hA, 64'd5000, 7'd0); dig(4'd2, 64'd5000, 7'd0);
    nop(1'b0, 64'd5000, 7'd0);
    nop(1'b1, 64'd5000, 7'd0);
    dig(4'd1, 64'd5000, 7'd0); dig(4'hA, 64'd5000, 7'd0); dig(4'd2, 64'd5000, 7'd0);
    dig(4'd3, 64'd5000, 7'd0); dig(4'd4, 64'd5000, 7'd0);
    nop(1'b1, 64'd5000, 7'd0);
    amt(1'b0, 1'b0, 32'd100, 1'b0, 64'd5000, 7'd0);
    // Warning persists across card reinsertion and clears on a correct PIN.
    nop(1'b1, 64'd5000, 7'd0);
    pin4(16'h1235, 64'd5000, 7'd0);
    nop(1'b1, 64'd5000, F_PIN);
    pin4(16'h9999, 64'd5000, 7'd0);
    nop(1'b1, 64'd5000, F_PIN | F_ADV);
    nop(1'b0, 64'd5000, F_ADV);
    nop(1'b1, 64'd5000, F_ADV);
    pin4(16'h1234, 64'd5000, F_ADV);
    nop(1'b1, 64'd5000, 7'd0);
    amt(1'b1, 1'b0, 32'd100, 1'b0, 64'd5100, F_BAL);
`ifdef DAILY_LIMIT_EN
    // Test 6: daily limit.
    rstv(64'd5000);
    login(64'd5000);
    amt(1'b1, 1'b1, 32'd600, 1'b0, 64'd4400, F_BAL | F_ENT);
    login(64'd4400);
    amt(1'b1, 1'b1, 32'd600, 1'b0, 64'd4400, F_LIM);
    login(64'd4400);
    amt(1'b1, 1'b1, 32'd600, 1'b1, 64'd3800, F_BAL | F_ENT);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; card = vecs[i].card; dstb = vecs[i].dstb; digit = vecs[i].digit;
      mstb = vecs[i].mstb; tipo = vecs[i].tipo; monto = vecs[i].monto; dia = vecs[i].dia;
      @(posedge clk);
      #1;
      act_flags = {bal, ent, pin, adv, blq, fon, lim};
      $display("rec %0d saldo=%0d flags=%b", i, saldo, act_flags);
      checks++;
      if (saldo !== vecs[i].exp_saldo) begin
        errors++;
        $display("FAIL rec%0d saldo actual=%0d required=%0d", i, saldo, vecs[i].exp_saldo);
      end
      checks++;
      if (act_flags !== vecs[i].exp_flags) begin
        errors++;
        $display("FAIL rec%0d flags(bal,ent,pin,adv,blq,fon,lim) actual=%b required=%b",
                 i, act_flags, vecs[i].exp_flags);
      end
    end

    // Test 5: saturating deposit on the 16-bit instance.
    rst = 1'b1; card = 1'b0; dstb = 1'b0; mstb = 1'b0; tipo = 1'b0; monto = 32'd0; dia = 1'b0;
    monto2 = 16'h0100;
    @(posedge clk); #1;
    $display("w16 reset saldo=%h", saldo2);
    cmp16("w16_reset_saldo", saldo2, 16'hFFF0);
    rst = 1'b0; card = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      dstb = 1'b1; digit = 4'(k + 1);
      @(posedge clk); #1;
    end
    dstb = 1'b0;
    @(posedge clk); #1;
    mstb = 1'b1;
    @(posedge clk); #1;
    mstb = 1'b0;
    $display("w16 deposit saldo=%h bal=%b", saldo2, bal2);
    cmp16("w16_sat_saldo", saldo2, 16'hFFFF);
    cmp16("w16_sat_bal", {15'd0, bal2}, 16'd1);
    @(posedge clk); #1;
    cmp16("w16_bal_one_cycle", {15'd0, bal2}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_controller_param.md
Name: atm_controller_param

Overview:
Parametrised next-generation ATM session controller. It adds configurable PIN length, a configurable attempt limit, configurable amount and balance widths, a visible balance, and saturating deposits. It sits behind the card reader, keypad and dispenser front end and owns the account balance register. It drops into the existing tester/testbench harness style, with `clk` and `rst` named the same way.

Parameters:
- PIN_DIGITS, 4, number of BCD digits in the PIN (1..8).
- PIN, 16'h1234, correct PIN, BCD, width 4*PIN_DIGITS; first digit entered is most significant.
- MAX_ATTEMPTS, 3, consecutive failed PIN checks before lockout (>=1).
- MONTO_WIDTH, 32, width of the amount input.
- BALANCE_WIDTH, 64, width of the balance register (>= MONTO_WIDTH).
- INIT_BALANCE, 5000, balance value loaded at reset.
- DAILY_LIMIT, 1000, withdrawal cap per day; used only with DAILY_LIMIT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- tarjeta_recibida  in  1  card present (level).
- digito_stb  in  1  one-cycle strobe qualifying `digito`.
- digito  in  4  BCD keypad digit.
- tipo_trans  in  1  0 = deposit, 1 = withdrawal; sampled with `monto_stb`.
- monto_stb  in  1  one-cycle strobe qualifying `monto`.
- monto  in  MONTO_WIDTH  transaction amount.
- saldo  out  BALANCE_WIDTH  current balance (registered).
- balance_actualizado  out  1  one-cycle pulse: balance changed.
- entregar_dinero  out  1  one-cycle pulse: dispense cash.
- pin_incorrecto  out  1  one-cycle pulse: PIN check failed.
- advertencia  out  1  level: exactly one attempt remains.
- bloqueo  out  1  level: account locked.
- fondos_insuficientes  out  1  one-cycle pulse: withdrawal rejected for insufficient balance.
- dia_nuevo  in  1  (DAILY_LIMIT_EN only) one-cycle pulse clearing the daily accumulator.
- limite_excedido  out  1  (DAILY_LIMIT_EN only) one-cycle pulse: withdrawal rejected by the daily limit.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; `saldo` = INIT_BALANCE.
  - Fail counter, digit count, PIN buffer and daily accumulator = 0.
  - All pulse and level outputs = 0.
  - Reset mid-session aborts the session immediately and clears the lock.
- All outputs are registered. Each pulse appears the cycle after the triggering strobe or check.
- States: IDLE, PIN_ENTRY, PIN_CHECK, AMOUNT_WAIT, LOCKED.
- IDLE:
  - `tarjeta_recibida`=1 -> PIN_ENTRY; digit count and buffer cleared.
- PIN_ENTRY:
  - `digito_stb` with `digito` <= 9: shift the digit into the buffer and increment the count.
  - `digito` > 9: ignored, not counted.
  - When the count reaches PIN_DIGITS -> PIN_CHECK.
- PIN_CHECK (one cycle), buffer compared to PIN:
  - Match: fail counter = 0, `advertencia` = 0 -> AMOUNT_WAIT.
  - Mismatch: fail counter +1 and `pin_incorrecto` pulses.
    - New count == MAX_ATTEMPTS -> LOCKED.
    - New count == MAX_ATTEMPTS-1 -> `advertencia` = 1 (held); -> PIN_ENTRY with count cleared.
    - Otherwise -> PIN_ENTRY with count cleared.
- AMOUNT_WAIT, on `monto_stb` (`monto` zero-extended to BALANCE_WIDTH), then -> IDLE:
  - Deposit: `saldo` = `saldo` + `monto`, saturating at all-ones; `balance_actualizado` pulses.
  - Withdrawal with `monto` <= `saldo`: `saldo` -= `monto`; `balance_actualizado` and `entregar_dinero` pulse together.
  - Withdrawal with `monto` > `saldo`: `fondos_insuficientes` pulses; `saldo` unchanged.
- LOCKED:
  - `bloqueo` = 1; all inputs ignored.
  - Exit only by `rst`.
- Card removal:
  - `tarjeta_recibida`=0 in PIN_ENTRY, PIN_CHECK or AMOUNT_WAIT -> IDLE next cycle, with no pulse.
  - Card removal wins over a simultaneous `digito_stb` or `monto_stb`.
  - The fail counter and `advertencia` persist across card reinsertion.
- Strobes outside their states:
  - `digito_stb` outside PIN_ENTRY is ignored.
  - `monto_stb` outside AMOUNT_WAIT is ignored.
- MAX_ATTEMPTS = 1: `advertencia` never asserts.

Optional Feature:
DAILY_LIMIT_EN:
- Defined:
  - Ports `dia_nuevo` and `limite_excedido` exist.
  - A BALANCE_WIDTH accumulator tracks withdrawn total.
  - A withdrawal with accumulator + `monto` > DAILY_LIMIT is rejected: `limite_excedido` pulses, `saldo` and accumulator unchanged.
  - The limit check takes priority over the funds check.
  - A successful withdrawal adds `monto` to the accumulator.
  - `dia_nuevo` clears the accumulator in the same cycle; a same-cycle withdrawal is checked against 0.
- Undefined:
  - Ports, accumulator and check are absent.
  - Withdrawals are limited only by balance.

Test Plan:
1. `rst`; card; digits 1,2,3,4 -> PIN_CHECK then AMOUNT_WAIT, no `pin_incorrecto`. Deposit 500 -> `balance_actualizado` 1 cycle, `saldo`=5500.
2. Correct PIN; withdraw 6000 at `saldo`=5500 -> `fondos_insuficientes` 1 cycle, `entregar_dinero`=0, `saldo`=5500. Withdraw 500 -> `entregar_dinero` and `balance_actualizado` pulse, `saldo`=5000.
3. Wrong PIN 1,2,3,5 twice -> two `pin_incorrecto` pulses; `advertencia`=1 after the second. Third wrong -> `bloqueo`=1; later card/digits/amount ignored; `rst` -> `bloqueo`=0, `saldo`=5000.
4. Digits 1, 4'hA, 2 -> count 2; card removed -> IDLE. Reinsert; digits 1,2,3,4 -> AMOUNT_WAIT. Card dropped in the same cycle as `monto_stb` -> no pulse, `saldo` unchanged.
5. BALANCE_WIDTH=16, MONTO_WIDTH=16, INIT_BALANCE=16'hFFF0; deposit 16'h0100 -> `saldo`=16'hFFFF, `balance_actualizado` pulses.
6. DAILY_LIMIT_EN, `saldo`=5000: withdraw 600 -> ok. Withdraw 600 -> `limite_excedido`, `saldo`=4400. `dia_nuevo`; withdraw 600 -> ok, `saldo`=3800.
